// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions.
//   fault_t / FLT_*  - instruction-fetch fault codes
//   imem_state_e     - program-memory load FSM states
//   NOP_INSTR        - encoding of sll $0,$0,0
package cpu_pkg;

    typedef logic [1:0] fault_t;

    localparam fault_t FLT_NONE     = 2'b00;
    localparam fault_t FLT_MISALIGN = 2'b01;
    localparam fault_t FLT_RANGE    = 2'b10;
    localparam fault_t FLT_NOTREADY = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } imem_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/prog_imem_if.sv
// prog_imem_if: program-load and instruction-fetch bus of prog_imem.
//   master - loader/core side: drives load_* and fetch_*, sees status + instr
//   slave  - memory side
interface prog_imem_if import cpu_pkg::*; #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
);
    localparam int PLEN_W = $clog2(DEPTH_WORDS) + 1;

    logic              load_start;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_busy;
    logic              load_overflow;
    logic [PLEN_W-1:0] prog_len;

    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [31:0]       instr;
    logic              instr_valid;
    fault_t            fetch_fault;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_en, fetch_addr,
        input  load_busy, load_overflow, prog_len, instr, instr_valid, fetch_fault
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_en, fetch_addr,
        output load_busy, load_overflow, prog_len, instr, instr_valid, fetch_fault
    );

endinterface

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: load FSM for prog_imem.
//   in : clk, rst (sync, active high), load_start, load_valid, load_last
//   out: wr_en/wr_idx (storage write port), state, prog_len, load_overflow
module imem_load_ctrl import cpu_pkg::*; #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS),
    parameter int PLEN_W      = $clog2(DEPTH_WORDS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output imem_state_e       state,
    output logic [PLEN_W-1:0] prog_len,
    output logic              load_overflow
);

    localparam logic [PLEN_W-1:0] FULL = PLEN_W'(DEPTH_WORDS);

    imem_state_e       state_q, state_d;
    logic [PLEN_W-1:0] plen_q, plen_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        plen_d  = plen_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        if (load_start) begin
            // restart beats any word offered in the same cycle
            state_d = ST_LOADING;
            plen_d  = '0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_LOADING && load_valid) begin
            if (plen_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                wr_en  = 1'b1;
                plen_d = plen_q + PLEN_W'(1);
            end
            if (load_last) state_d = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            plen_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            plen_q  <= plen_d;
            ovf_q   <= ovf_d;
        end
    end

    // Words are written in order from 0 and the count saturates at full,
    // so the count doubles as the write pointer; it never wraps.
    assign wr_idx        = plen_q[IDX_W-1:0];
    assign state         = state_q;
    assign prog_len      = plen_q;
    assign load_overflow = ovf_q;

endmodule

// File: rtl/prog_imem.sv
// prog_imem: loadable instruction memory with registered, checked fetch.
//   clk, rst           - clock, synchronous active-high reset
//   bus (slave)        - program-load port (load_*, status) and fetch port
//                        (fetch_en/fetch_addr in, instr/instr_valid/fetch_fault
//                        out, one cycle after the request)
module prog_imem import cpu_pkg::*; #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
    input  logic       clk,
    input  logic       rst,
    prog_imem_if.slave bus
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int PLEN_W = IDX_W + 1;
    // compare width large enough for both the address and 4*prog_len
    localparam int CW     = (ADDR_W > PLEN_W + 2) ? ADDR_W : PLEN_W + 2;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    imem_state_e       state;
    logic [PLEN_W-1:0] prog_len;
    logic              load_overflow;

    imem_load_ctrl #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .PLEN_W      (PLEN_W)
    ) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .load_start    (bus.load_start),
        .load_valid    (bus.load_valid),
        .load_last     (bus.load_last),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .state         (state),
        .prog_len      (prog_len),
        .load_overflow (load_overflow)
    );

    // Storage is deliberately not reset; words past prog_len are fenced
    // off by the range check instead. Words are stored as delivered, so
    // bits [31:24] hold byte 0 (big-endian).
    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= bus.load_data;
    end

    logic [IDX_W-1:0] rd_idx;
    logic [CW-1:0]    addr_ext, lim_ext;

    assign rd_idx   = bus.fetch_addr[2 +: IDX_W];
    // full-width compare also catches nonzero bits above the word index
    assign addr_ext = CW'(bus.fetch_addr);
    assign lim_ext  = CW'({prog_len, 2'b00});

    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    fault_t      fault_q, fault_d;

    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (bus.fetch_en) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            // a restart pulse blocks fetch at the same edge it leaves READY
            if (state != ST_READY || bus.load_start) begin
                fault_d = FLT_NOTREADY;
            end else if (bus.fetch_addr[1:0] != 2'b00) begin
                fault_d = FLT_MISALIGN;
            end else if (addr_ext >= lim_ext) begin
                fault_d = FLT_RANGE;
            end else begin
                fault_d = FLT_NONE;
                instr_d = mem_q[rd_idx];
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= FLT_NONE;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign bus.instr         = instr_q;
    assign bus.instr_valid   = valid_q;
    assign bus.fetch_fault   = fault_q;
    assign bus.load_busy     = (state == ST_LOADING);
    assign bus.load_overflow = load_overflow;
    assign bus.prog_len      = prog_len;

endmodule

// File: tb/tb_prog_imem.sv
// tb_prog_imem: drives the same random/directed stream into a 64-word and a
// 4-word prog_imem; a reference model per instance queues expected results,
// a monitor pops and compares them after each clock edge.
module tb_prog_imem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, ls = 1'b0, lv = 1'b0, ll = 1'b0, fe = 1'b0;
    logic [31:0] ld = '0, fa = '0;

    prog_imem_if #(.DEPTH_WORDS(64), .ADDR_W(32)) bus64 ();
    prog_imem_if #(.DEPTH_WORDS(4),  .ADDR_W(32)) bus4 ();

    assign bus64.load_start = ls;  assign bus4.load_start = ls;
    assign bus64.load_valid = lv;  assign bus4.load_valid = lv;
    assign bus64.load_data  = ld;  assign bus4.load_data  = ld;
    assign bus64.load_last  = ll;  assign bus4.load_last  = ll;
    assign bus64.fetch_en   = fe;  assign bus4.fetch_en   = fe;
    assign bus64.fetch_addr = fa;  assign bus4.fetch_addr = fa;

    prog_imem #(.DEPTH_WORDS(64), .ADDR_W(32), .NOP_WORD(32'h0)) dut64 (
        .clk(clk), .rst(rst), .bus(bus64.slave));
    prog_imem #(.DEPTH_WORDS(4), .ADDR_W(32), .NOP_WORD(32'h0)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave));

    logic [31:0] o_instr [2];
    logic        o_v [2], o_busy [2], o_ovf [2];
    logic [1:0]  o_f [2];
    logic [7:0]  o_plen [2];
    assign o_instr[0] = bus64.instr;       assign o_instr[1] = bus4.instr;
    assign o_v[0]     = bus64.instr_valid; assign o_v[1]     = bus4.instr_valid;
    assign o_f[0]     = bus64.fetch_fault; assign o_f[1]     = bus4.fetch_fault;
    assign o_busy[0]  = bus64.load_busy;   assign o_busy[1]  = bus4.load_busy;
    assign o_ovf[0]   = bus64.load_overflow; assign o_ovf[1] = bus4.load_overflow;
    assign o_plen[0]  = 8'(bus64.prog_len); assign o_plen[1] = 8'(bus4.prog_len);

    typedef struct packed { logic [31:0] instr; logic v; logic [1:0] f; } fx_t;
    typedef struct packed { logic busy; logic ovf; logic [7:0] plen; } st_t;
    typedef fx_t [1:0] fpair_t;
    typedef st_t [1:0] spair_t;

    fpair_t fq [$];
    spair_t sq [$];
    int checks = 0, failures = 0;

    // reference model: contents, word count and simple mode flags per instance
    int          depth [2] = '{64, 4};
    logic [31:0] m_mem [2][64];
    int          m_len [2] = '{0, 0};
    bit          m_ready [2] = '{0, 0};
    bit          m_loading [2] = '{0, 0};
    bit          m_ovf [2] = '{0, 0};

    function automatic fx_t exp_fetch(input int i, input bit r, input bit s,
                                      input logic [31:0] a);
        fx_t x;
        x.instr = 32'h0; x.v = 1'b0; x.f = 2'b00;
        if (r) return x;
        if (!m_ready[i] || s)                        x.f = 2'b11;
        else if (a[1:0] != 2'b00)                    x.f = 2'b01;
        else if (longint'(a) >= longint'(4 * m_len[i])) x.f = 2'b10;
        else begin
            x.v = 1'b1;
            x.instr = m_mem[i][a[7:2]];
        end
        return x;
    endfunction

    task automatic model_step(input int i, input bit r, input bit s, input bit v,
                              input logic [31:0] d, input bit l);
        if (r) begin
            m_ready[i] = 0; m_loading[i] = 0; m_len[i] = 0; m_ovf[i] = 0;
        end else if (s) begin
            m_ready[i] = 0; m_loading[i] = 1; m_len[i] = 0; m_ovf[i] = 0;
        end else if (m_loading[i] && v) begin
            if (m_len[i] == depth[i]) m_ovf[i] = 1;
            else begin
                m_mem[i][6'(m_len[i])] = d;
                m_len[i]++;
            end
            if (l) begin m_loading[i] = 0; m_ready[i] = 1; end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit v, input logic [31:0] d,
                       input bit l, input bit e, input logic [31:0] a);
        fpair_t fp;
        spair_t sp;
        @(negedge clk);
        rst = r; ls = s; lv = v; ld = d; ll = l; fe = e; fa = a;
        for (int i = 0; i < 2; i++) begin
            fp[i] = exp_fetch(i, r, s, a);
            model_step(i, r, s, v, d, l);
            sp[i].busy = m_loading[i];
            sp[i].ovf  = m_ovf[i];
            sp[i].plen = 8'(m_len[i]);
        end
        if (r || e) fq.push_back(fp);
        sq.push_back(sp);
        @(posedge clk);
    endtask

    // monitor
    fx_t last [2];
    bit  have_last = 0;
    always begin
        bit     cap;
        fpair_t fp;
        spair_t sp;
        @(posedge clk);
        cap = (fe === 1'b1) || (rst === 1'b1);
        #1;
        if (sq.size() > 0) begin
            sp = sq.pop_front();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_busy[i] !== sp[i].busy || o_ovf[i] !== sp[i].ovf ||
                    o_plen[i] !== sp[i].plen) begin
                    failures++;
                    $display("FAIL status[%0d] t=%0t got busy=%b ovf=%b len=%0d want busy=%b ovf=%b len=%0d",
                             i, $time, o_busy[i], o_ovf[i], o_plen[i],
                             sp[i].busy, sp[i].ovf, sp[i].plen);
                end
            end
        end
        if (cap) begin
            checks++;
            if (fq.size() == 0) begin
                failures++;
                $display("FAIL fetch_queue t=%0t got empty want entry", $time);
            end else begin
                fp = fq.pop_front();
                for (int i = 0; i < 2; i++) last[i] = fp[i];
                have_last = 1;
            end
        end
        if (have_last) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_instr[i] !== last[i].instr || o_v[i] !== last[i].v ||
                    o_f[i] !== last[i].f) begin
                    failures++;
                    $display("FAIL %s[%0d] t=%0t got instr=%h v=%b f=%b want instr=%h v=%b f=%b",
                             cap ? "fetch" : "hold", i, $time, o_instr[i], o_v[i], o_f[i],
                             last[i].instr, last[i].v, last[i].f);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prog [20];
        bit          r, s, v, l, e;
        logic [31:0] a, d;

        prog[0] = 32'h8E08_0000;
        for (int k = 1; k <= 9; k++) begin
            prog[2*k-1] = 32'h8E09_0000 | 32'(4 * k);
            prog[2*k]   = 32'h0109_4020;
        end
        prog[19] = 32'hAE08_0028;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h0);                 // not ready
        // 20-word program, fetch on the final beat still not ready
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cyc(0, 0, 1, prog[k], k == 19, k == 19, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 32'h00);
        cyc(0, 0, 0, 0, 0, 1, 32'h4C);
        cyc(0, 0, 0, 0, 0, 1, 32'h02);
        cyc(0, 0, 0, 0, 0, 1, 32'h50);
        cyc(0, 0, 0, 0, 0, 1, 32'h4000_0000);
        cyc(0, 0, 0, 0, 0, 1, 32'h00);                 // back to back
        cyc(0, 0, 0, 0, 0, 1, 32'h04);
        cyc(0, 0, 0, 0, 0, 1, 32'h08);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        // overflow on the 4-word instance
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) cyc(0, 0, 1, 32'hC0DE_0000 + 32'(k), k == 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h0C);
        cyc(0, 0, 0, 0, 0, 1, 32'h10);
        // restart during load, restart beat carries a dropped word
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 32'h1111_0000 + 32'(k), 0, 0, 0);
        cyc(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cyc(0, 0, 1, 32'h2222_0000, 0, 0, 0);
        cyc(0, 0, 1, 32'h2222_0001, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h08);
        cyc(0, 0, 0, 0, 0, 1, 32'h04);
        // restart from READY with a fetch on the same edge
        cyc(0, 1, 0, 0, 0, 1, 32'h00);
        cyc(0, 0, 0, 0, 0, 1, 32'h00);
        // reset mid-load
        cyc(0, 0, 1, 32'h3333_0000, 0, 0, 0);
        cyc(0, 0, 1, 32'h3333_0001, 0, 0, 0);
        cyc(1, 0, 1, 32'h3333_0002, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h00);

        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 11) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = $urandom;
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'($urandom_range(0, 80)) << 2;
                3:       a = 32'($urandom_range(0, 300));
                4:       a = $urandom;
                default: a = 32'(4 * m_len[$urandom_range(0, 1)]) - 32'($urandom_range(0, 1) * 4);
            endcase
            cyc(r, s, v, d, l, e, a);
        end
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        checks++;
        if (fq.size() != 0 || sq.size() != 0) begin
            failures++;
            $display("FAIL drain got fq=%0d sq=%0d want 0 0", fq.size(), sq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_imem.md
# prog_imem

Parametrised, loadable instruction memory for the single-cycle CPU. Replaces a fixed hard-coded program with a word-wide program-load port, filled by the testbench or a boot loader before the core runs. Instruction fetch is byte-addressed, big-endian and registered, with alignment and range checks. Sits between the PC register and the decoder.

## Interface
- `DEPTH_WORDS`, default 64: storage depth in 32-bit words; must be a power of two, at least 4.
- `ADDR_W`, default 32: width of the fetch byte address.
- `NOP_WORD`, default 32'h0000_0000: word returned on any fetch that is not valid (sll $0,$0,0).

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `load_start`, in, 1: one-cycle pulse that begins a new program load.
- `load_valid`, in, 1: `load_data` holds the next program word.
- `load_data`, in, 32: program word, written in sequence from word 0.
- `load_last`, in, 1: qualifies `load_valid`; marks the final word of the program.
- `load_busy`, out, 1: high while in LOADING.
- `load_overflow`, out, 1: sticky; a word was offered after the memory was full.
- `prog_len`, out, $clog2(DEPTH_WORDS)+1: number of words written in the current program.
- `fetch_en`, in, 1: fetch request.
- `fetch_addr`, in, ADDR_W: byte address, normally the PC.
- `instr`, out, 32: fetched instruction.
- `instr_valid`, out, 1: `instr` is a real program word.
- `fetch_fault`, out, 2: fault code. 00 = none, 01 = misaligned, 10 = beyond `prog_len`, 11 = not READY.

## Operation
- FSM with three states: EMPTY, LOADING, READY.
  - Reset enters EMPTY.
  - From any state, `load_start` goes to LOADING, clears the write pointer, `prog_len` and `load_overflow`.
  - In LOADING, a cycle with `load_valid` and `load_last` goes to READY.
  - If `load_start` and `load_valid` are high in the same cycle, the restart wins and the data word is dropped.
- Write pointer in LOADING: each `load_valid` writes `load_data` at the pointer, increments the pointer and increments `prog_len`.
- Full memory: once `prog_len` == DEPTH_WORDS, further `load_valid` words are dropped, `load_overflow` is set, and the pointer does not wrap. `load_last` still moves the FSM to READY.
- Byte order is big-endian: byte 0 of a word is bits [31:24].
- Word index is `fetch_addr[2 +: $clog2(DEPTH_WORDS)]`.
- Fetch checks, highest priority first:
  1. Not in READY: code 11.
  2. `fetch_addr[1:0]` ≠ 0: code 01.
  3. `fetch_addr` ≥ 4·`prog_len`, including any nonzero address bits above the index: code 10.
  4. Otherwise the fetch is valid.
- A fault drives `instr` = NOP_WORD and `instr_valid` = 0. A valid fetch drives the stored word and `instr_valid` = 1.
- `fetch_en` low holds `instr`, `instr_valid` and `fetch_fault` unchanged.
- Storage contents are not cleared by `rst` or by `load_start`. Words at or beyond `prog_len` are unreachable.

## Timing
- Reset values: `instr` = NOP_WORD, `instr_valid` = 0, `fetch_fault` = 00, `load_busy` = 0, `load_overflow` = 0, `prog_len` = 0; FSM in EMPTY.
- Fetch latency is 1 cycle: `fetch_en` sampled at edge N gives outputs valid after edge N, with throughput of one fetch per cycle. The core latches the PC accordingly.
- Load writes one word per cycle with no backpressure. `load_busy` rises the cycle after `load_start` and falls the cycle after the `load_last` beat.
- Read during the final load beat: a fetch at edge N, when edge N also writes the `load_last` word, still reports code 11. The first valid fetch is sampled at edge N+1.
- `rst` mid-load aborts the load: EMPTY, `prog_len` = 0. Words already written remain in storage but are unreachable.
- `load_start` during READY drops to LOADING at the next edge. Fetches sampled from that edge onward report code 11.

## Structure
- Shared CPU package `cpu_pkg` holds:
  - the fault-code constants (`FLT_NONE`, `FLT_MISALIGN`, `FLT_RANGE`, `FLT_NOTREADY`);
  - the FSM state enum;
  - the NOP encoding.
- One natural sub-module, `imem_load_ctrl`: the FSM, write pointer, `prog_len` and overflow logic.
- The storage array and the fetch path stay in `prog_imem`.

## Test plan
- Load path: reset, then load the 20-word sum program (lw/add ×9, then sw 40($s0); final word 32'hAE08_0028 with `load_last`) → `prog_len` = 20, READY.
  - Fetch 0x00 → 32'h8E08_0000, valid.
  - Fetch 0x4C → 32'hAE08_0028, valid.
- Alignment and range: with the 20-word program loaded, fetch 0x02 → fault 01, `instr` = 0. Fetch 0x50 → fault 10. Fetch 0x4000_0000 → fault 10.
- Overflow: with DEPTH_WORDS = 4, offer 6 words with `load_last` on the 6th → `prog_len` = 4, `load_overflow` = 1, READY. Fetch 0x0C returns the 4th word.
- Restart during load: `load_start` after 3 words, then load 2 words ending in `load_last` → `prog_len` = 2. Fetch 0x08 → fault 10.
- Reset mid-load and not-ready fetch: `rst` during LOADING → all outputs at reset values. Fetch 0x00 → fault 11.
- Back-to-back fetch: fetch 0x00, 0x04, 0x08 on consecutive cycles → three consecutive valid words, each one cycle late.
